// File: rtl/sata_oobdetect_pkg.sv
// Shared OOB definitions: FSM states, gap classes, default cycle constants and
// the gap classifier, common to the receive detector and the transmit generator.
package sata_oobdetect_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2,
    S_HOLD  = 2'd3
  } oob_state_e;

  typedef enum logic [1:0] {
    GAP_NONE = 2'd0,
    GAP_WAKE = 2'd1,
    GAP_INIT = 2'd2,
    GAP_BAD  = 2'd3
  } gap_class_e;

  localparam int unsigned DEF_NBURSTS      = 4;
  localparam int unsigned DEF_MIN_BURST    = 5;
  localparam int unsigned DEF_MAX_BURST    = 12;
  localparam int unsigned DEF_MIN_WAKE_GAP = 5;
  localparam int unsigned DEF_MAX_WAKE_GAP = 12;
  localparam int unsigned DEF_MIN_INIT_GAP = 18;
  localparam int unsigned DEF_MAX_INIT_GAP = 36;

  function automatic gap_class_e classify_gap(input int unsigned len,
                                              input int unsigned min_wake,
                                              input int unsigned max_wake,
                                              input int unsigned min_init,
                                              input int unsigned max_init);
    if (len >= min_wake && len <= max_wake) return GAP_WAKE;
    if (len >= min_init && len <= max_init) return GAP_INIT;
    return GAP_BAD;
  endfunction

endpackage

// File: rtl/sata_sync2.sv
// Generic 2-FF synchronizer with asynchronous active-high reset.
module sata_sync2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ff1_q <= RESET_VAL;
      ff2_q <= RESET_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/sata_oobdetect.sv
// Receive-side OOB burst/gap decoder producing one-cycle COMINIT/COMWAKE pulses.
// Optional SATA_OOB_DEGLITCH_EN inserts a 3-sample majority filter after the synchronizer.
module sata_oobdetect
  import sata_oobdetect_pkg::*;
#(
  parameter int unsigned NBURSTS      = DEF_NBURSTS,
  parameter int unsigned MIN_BURST    = DEF_MIN_BURST,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned MIN_WAKE_GAP = DEF_MIN_WAKE_GAP,
  parameter int unsigned MAX_WAKE_GAP = DEF_MAX_WAKE_GAP,
  parameter int unsigned MIN_INIT_GAP = DEF_MIN_INIT_GAP,
  parameter int unsigned MAX_INIT_GAP = DEF_MAX_INIT_GAP
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_elecidle,
  output logic o_cominit,
  output logic o_comwake,
  output logic o_busy
);

  localparam int unsigned    CW      = $clog2(MAX_INIT_GAP + 2);
  localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_INIT_GAP + 1);

  logic idle_sync;
  logic idle_s;

  sata_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .d_i   (i_elecidle),
    .q_o   (idle_sync)
  );

`ifdef SATA_OOB_DEGLITCH_EN
  logic [1:0] hist_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) hist_q <= '1;
    else         hist_q <= {hist_q[0], idle_sync};
  end

  assign idle_s = (idle_sync & hist_q[0]) | (idle_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign idle_s = idle_sync;
`endif

  oob_state_e    state_q, state_d;
  gap_class_e    cls_q, cls_d;
  gap_class_e    gcls;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nb_q, nb_d;
  logic [3:0]    nb_inc;
  logic          idle_q;
  logic          cominit_q, cominit_d;
  logic          comwake_q, comwake_d;
  logic          rise, fall;
  logic          burst_ok;
  int unsigned   cnt_len;

  assign rise     = idle_s & ~idle_q;
  assign fall     = ~idle_s & idle_q;
  assign cnt_len  = 32'(cnt_q);
  assign burst_ok = (cnt_len >= MIN_BURST) && (cnt_len <= MAX_BURST);
  assign gcls     = classify_gap(cnt_len, MIN_WAKE_GAP, MAX_WAKE_GAP, MIN_INIT_GAP, MAX_INIT_GAP);
  assign nb_inc   = nb_q + 4'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cls_q     <= GAP_NONE;
      cnt_q     <= '0;
      nb_q      <= '0;
      idle_q    <= 1'b1;
      cominit_q <= 1'b0;
      comwake_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      nb_q      <= nb_d;
      idle_q    <= idle_s;
      cominit_q <= cominit_d;
      comwake_q <= comwake_d;
    end
  end

  // Restarting at 1 makes the count seen in an edge cycle equal the length of the level just ended.
  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall)          cnt_d = CW'(1);
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    nb_d      = nb_q;
    cominit_d = 1'b0;
    comwake_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!idle_s) begin
          state_d = S_BURST;
          nb_d    = '0;
          cls_d   = GAP_NONE;
        end
      end

      S_BURST: begin
        if (rise) begin
          if (!burst_ok) begin
            state_d = S_IDLE;
            nb_d    = '0;
            cls_d   = GAP_NONE;
          end else begin
            nb_d = nb_inc;
            if (nb_inc == 4'(NBURSTS)) begin
              cominit_d = (cls_q == GAP_INIT);
              comwake_d = (cls_q == GAP_WAKE);
              state_d   = S_HOLD;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        // Saturation wins over a simultaneous fall: a 37+ cycle gap always ends the sequence.
        if (cnt_q == CNT_SAT) begin
          state_d = S_IDLE;
          nb_d    = '0;
          cls_d   = GAP_NONE;
        end else if (fall) begin
          state_d = S_BURST;
          if (gcls == GAP_BAD) begin
            nb_d  = '0;
            cls_d = GAP_NONE;
          end else if (cls_q == GAP_NONE) begin
            cls_d = gcls;
          end else if (gcls != cls_q) begin
            cls_d = gcls;
            nb_d  = 4'd1;
          end
        end
      end

      S_HOLD: begin
        if (idle_q && cnt_q == CNT_SAT) begin
          state_d = S_IDLE;
          nb_d    = '0;
          cls_d   = GAP_NONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_cominit = cominit_q;
  assign o_comwake = comwake_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_sata_oobdetect.sv
// Scoreboard bench for sata_oobdetect: burst/gap trains checked against a
// segment-level model of the OOB decoding rules.
module tb_sata_oobdetect;

  localparam int NB    = 4;
  localparam int MIN_B = 5;
  localparam int MAX_B = 12;
  localparam int MIN_W = 5;
  localparam int MAX_W = 12;
  localparam int MIN_I = 18;
  localparam int MAX_I = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic elecidle = 1'b1;
  logic cominit, comwake, busy;

  sata_oobdetect #(
    .NBURSTS      (NB),
    .MIN_BURST    (MIN_B),
    .MAX_BURST    (MAX_B),
    .MIN_WAKE_GAP (MIN_W),
    .MAX_WAKE_GAP (MAX_W),
    .MIN_INIT_GAP (MIN_I),
    .MAX_INIT_GAP (MAX_I)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_elecidle (elecidle),
    .o_cominit  (cominit),
    .o_comwake  (comwake),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_init;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  // Segment-level model: sequence progress tracked per completed burst and gap.
  int m_nb     = 0;
  int m_cls    = 0;  // 0 none, 1 wake, 2 init
  bit m_active = 0;
  bit m_hold   = 0;
  bit m_busy   = 0;
  int last_gap = 1000;

  function automatic void m_reset();
    m_nb = 0; m_cls = 0; m_active = 0; m_hold = 0; m_busy = 0;
  endfunction

  function automatic void m_gap_end(input int g);
    int c;
    if (m_hold) begin
      if (g > MAX_I) begin m_hold = 0; m_active = 0; end
      return;
    end
    if (!m_active) return;
    c = (g >= MIN_W && g <= MAX_W) ? 1 : (g >= MIN_I && g <= MAX_I) ? 2 : 0;
    if (c == 0) begin m_nb = 0; m_cls = 0; end
    else if (m_cls == 0) m_cls = c;
    else if (c != m_cls) begin m_cls = c; m_nb = 1; end
  endfunction

  function automatic void m_burst_start();
    if (!m_active && !m_hold) begin m_active = 1; m_nb = 0; m_cls = 0; end
  endfunction

  function automatic void m_burst_end(input int bl, input int unsigned n);
    exp_t e;
    if (m_hold) begin m_busy = 1; return; end
    if (bl < MIN_B || bl > MAX_B) begin
      m_active = 0; m_nb = 0; m_cls = 0; m_busy = 0;
      return;
    end
    m_nb++;
    m_busy = 1;
    if (m_nb == NB) begin
      e.is_init = (m_cls == 2);
      e.cyc     = n + 3;
      exp_q.push_back(e);
      m_hold = 1;
    end
  endfunction

  task automatic check(input string name, input logic act, input logic expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (cominit || comwake)) begin
      compared++;
      if (cominit && comwake) begin
        mismatched++;
        $display("FAIL both_pulses: cominit=1 comwake=1 at cycle %0d, required never together", cyc);
      end else if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: cominit=%0b comwake=%0b at cycle %0d, none expected", cominit, comwake, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_init != cominit || mon_e.cyc != cyc) begin
          mismatched++;
          $display("FAIL pulse: got cominit=%0b at cycle %0d, expected cominit=%0b at cycle %0d",
                   cominit, cyc, mon_e.is_init, mon_e.cyc);
        end
      end
    end
  end

  task automatic seg(input int bl, input int gl);
    for (int i = 0; i < bl; i++) begin
      @(negedge clk);
      if (i == 0) begin m_gap_end(last_gap); m_burst_start(); end
      elecidle = 1'b0;
    end
    for (int i = 0; i < gl; i++) begin
      @(negedge clk);
      if (i == 0) m_burst_end(bl, cyc);
      if (i == 5) check("busy_mid_gap", busy, m_busy);
      if (gl >= 42 && i == gl - 1) check("busy_after_long_idle", busy, 1'b0);
      elecidle = 1'b1;
    end
    last_gap = gl;
  endtask

  function automatic int pick_burst();
    int b[6] = '{3, 4, 5, 12, 13, 14};
    if ($urandom_range(9, 0) < 7) return int'($urandom_range(10, 6));
    return b[$urandom_range(5, 0)];
  endfunction

  function automatic int pick_gap(input bit wake);
    int b[11] = '{2, 4, 5, 12, 13, 15, 17, 18, 36, 37, 40};
    if ($urandom_range(9, 0) < 7)
      return wake ? int'($urandom_range(11, 6)) : int'($urandom_range(34, 20));
    return b[$urandom_range(10, 0)];
  endfunction

  initial begin
    repeat (3) begin
      @(negedge clk);
      check("reset_cominit", cominit, 1'b0);
      check("reset_comwake", comwake, 1'b0);
      check("reset_busy", busy, 1'b0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // COMINIT: 4 bursts, 24-cycle gaps
    repeat (3) seg(8, 24);
    seg(8, 45);

    // COMWAKE: 6 bursts, 8-cycle gaps, then long idle
    repeat (5) seg(8, 8);
    seg(8, 45);

    // Short bursts never qualify
    repeat (3) seg(3, 24);
    seg(3, 45);

    // Class switch INIT -> WAKE restarts the count
    seg(8, 24); seg(8, 24); seg(8, 8); seg(8, 8); seg(8, 8);
    seg(8, 45);

    // In-between gap restarts; COMINIT after 4 post-gap bursts
    seg(8, 24); seg(8, 15); seg(8, 24); seg(8, 24); seg(8, 24);
    seg(8, 45);

    // Reset during burst 3 of a COMINIT sequence
    seg(8, 24); seg(8, 24);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin m_gap_end(last_gap); m_burst_start(); end
      elecidle = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    check("async_reset_cominit", cominit, 1'b0);
    check("async_reset_comwake", comwake, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("in_reset_busy", busy, 1'b0);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i < 3) check("in_reset_busy", busy, 1'b0);
      if (i == 3) rst = 1'b0;
      elecidle = 1'b1;
    end
    last_gap = 24;
    seg(8, 24);
    seg(8, 45);

    // Randomized trains
    for (int t = 0; t < 40; t++) begin
      int  n;
      bit  wake;
      n    = int'($urandom_range(7, 1));
      wake = 1'($urandom_range(1, 0));
      for (int b = 0; b < n; b++) begin
        if (b == n - 1 && $urandom_range(2, 0) == 0) seg(pick_burst(), 45);
        else                                         seg(pick_burst(), pick_gap(wake));
      end
    end
    seg(8, 45);

    repeat (10) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
